// File: rtl/mmss_counter.sv
`default_nettype none
// ============================================================================
// Module   : mmss_counter
// Brief    : Minutes:seconds BCD counter (00:00..59:59) with built-in
//            prescaler, pause, field-adjust mode and rollover pulse.
//            Optional macro MMSS_SATURATE_EN: run mode stops at 59:59.
// Revision : 1.0  initial release
// ============================================================================
module mmss_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int ADJ_DIV  = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PAUSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] SEC_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] MIN_TENS,
  output logic       TICK,
  output logic       WRAP
);

  localparam int MAX_DIV = (TICK_DIV > ADJ_DIV) ? TICK_DIV : ADJ_DIV;
  localparam int PW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
  localparam logic [PW-1:0] TICK_TERM = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ADJ_TERM  = PW'(ADJ_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          adj_q, adj_d;
  logic [7:0]    sec_q, sec_d;   // {tens, ones}
  logic [7:0]    min_q, min_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] term;
  logic          inc;
  logic          at_max;

  // One step of a 00..59 BCD field; >= comparisons pull any stray digit back in range.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones >= 4'd9) begin
      ones = 4'd0;
      tens = (tens >= 4'd5) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  always_comb begin
    presc_d = presc_q;
    adj_d   = ADJ;
    sec_d   = sec_q;
    min_d   = min_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    inc     = 1'b0;
    term    = ADJ ? ADJ_TERM : TICK_TERM;
    at_max  = (sec_q == 8'h59) && (min_q == 8'h59);

    if (ADJ != adj_q) begin
      presc_d = '0;
    end else if (!ADJ && PAUSE) begin
      presc_d = presc_q;
    end else if (presc_q >= term) begin
      presc_d = '0;
      inc     = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (inc) begin
      if (ADJ) begin
        tick_d = 1'b1;
        if (SEL) begin
          min_d = bcd60_inc(min_q);
        end else begin
          sec_d = bcd60_inc(sec_q);
        end
      end else begin
`ifdef MMSS_SATURATE_EN
        if (!at_max) begin
          tick_d = 1'b1;
          sec_d  = bcd60_inc(sec_q);
          if (sec_q == 8'h59) begin
            min_d = bcd60_inc(min_q);
          end
        end
`else
        tick_d = 1'b1;
        wrap_d = at_max;
        sec_d  = bcd60_inc(sec_q);
        if (sec_q == 8'h59) begin
          min_d = bcd60_inc(min_q);
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
      adj_q   <= 1'b0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      adj_q   <= adj_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign SEC_ONES = sec_q[3:0];
  assign SEC_TENS = sec_q[7:4];
  assign MIN_ONES = min_q[3:0];
  assign MIN_TENS = min_q[7:4];
  assign TICK     = tick_q;
  assign WRAP     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_mmss_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmss_counter
// Brief    : Directed vector bench for mmss_counter (TICK_DIV=4, ADJ_DIV=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_mmss_counter;

  typedef struct {
    logic        rst;
    logic        pause;
    logic        adj;
    logic        sel;
    int          n;      // clock edges to apply before checking
    logic [15:0] exp;    // {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES}
    logic        tick;
    logic        wrap;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       tick, wrap;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mmss_counter #(.TICK_DIV(4), .ADJ_DIV(2)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .PAUSE    (pause),
    .ADJ      (adj),
    .SEL      (sel),
    .SEC_ONES (sec_ones),
    .SEC_TENS (sec_tens),
    .MIN_ONES (min_ones),
    .MIN_TENS (min_tens),
    .TICK     (tick),
    .WRAP     (wrap)
  );

  task automatic add(input logic r, input logic p, input logic a, input logic s,
                     input int n, input logic [15:0] e, input logic t, input logic w);
    vec_t v;
    v.rst = r; v.pause = p; v.adj = a; v.sel = s;
    v.n = n; v.exp = e; v.tick = t; v.wrap = w;
    tbl.push_back(v);
  endtask

  task automatic apply_check(input vec_t v, input string name);
    logic [15:0] got;
    rst = v.rst; pause = v.pause; adj = v.adj; sel = v.sel;
    repeat (v.n) @(posedge clk);
    #1;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    n_vec++;
    if (got !== v.exp || tick !== v.tick || wrap !== v.wrap) begin
      n_err++;
      $display("FAIL %s: got %h tick=%b wrap=%b, expected %h tick=%b wrap=%b",
               name, got, tick, wrap, v.exp, v.tick, v.wrap);
    end
  endtask

  task automatic chk(input logic r, input logic p, input logic a, input logic s,
                     input int n, input logic [15:0] e, input logic t, input logic w,
                     input string name);
    vec_t v;
    v.rst = r; v.pause = p; v.adj = a; v.sel = s;
    v.n = n; v.exp = e; v.tick = t; v.wrap = w;
    apply_check(v, name);
  endtask

  initial begin
    // Reset, then run: increments on edges 4, 8, ..., 40
    add(1, 0, 0, 0,   2, 16'h0000, 0, 0);
    add(0, 0, 0, 0,   3, 16'h0000, 0, 0);
    add(0, 0, 0, 0,   1, 16'h0001, 1, 0);
    add(0, 0, 0, 0,   1, 16'h0001, 0, 0);
    add(0, 0, 0, 0,  35, 16'h0010, 1, 0);
    // Pause for 7 cycles with prescaler at 2: increment moves from edge 44 to 51
    add(0, 0, 0, 0,   2, 16'h0010, 0, 0);
    add(0, 1, 0, 0,   3, 16'h0010, 0, 0);
    add(0, 1, 0, 0,   4, 16'h0010, 0, 0);
    add(0, 0, 0, 0,   1, 16'h0010, 0, 0);
    add(0, 0, 0, 0,   1, 16'h0011, 1, 0);
    // Adjust seconds 11 -> 30: mode-change edge, then 19 increments at 2-cycle spacing
    add(0, 0, 1, 0,   1, 16'h0011, 0, 0);
    add(0, 0, 1, 0,  38, 16'h0030, 1, 0);
    // Adjust minutes from 00:30
    add(0, 0, 1, 1,   2, 16'h0130, 1, 0);
    add(0, 0, 1, 1,   2, 16'h0230, 1, 0);
    add(0, 0, 1, 1,   1, 16'h0230, 0, 0);
    add(0, 0, 1, 1,   1, 16'h0330, 1, 0);
    // PAUSE does not stop adjust mode
    add(0, 1, 1, 1,   2, 16'h0430, 1, 0);
    add(0, 0, 1, 1, 110, 16'h5930, 1, 0);
    add(0, 0, 1, 1,   2, 16'h0030, 1, 0);
    // Seconds field wraps 59 -> 00 without touching minutes
    add(0, 0, 1, 0,  58, 16'h0059, 1, 0);
    add(0, 0, 1, 0,   2, 16'h0000, 1, 0);
    // Preload 59:58
    add(0, 0, 1, 1, 118, 16'h5900, 1, 0);
    add(0, 0, 1, 0, 116, 16'h5958, 1, 0);
    // Back to run mode: mode-change edge, then increments every 4 edges
    add(0, 0, 0, 0,   4, 16'h5958, 0, 0);
    add(0, 0, 0, 0,   1, 16'h5959, 1, 0);
    add(0, 0, 0, 0,   3, 16'h5959, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_check(tbl[i], $sformatf("vec%0d", i));
    end

    // Rollover edge and the cycle after it, checked one edge at a time
`ifdef MMSS_SATURATE_EN
    chk(0, 0, 0, 0, 1, 16'h5959, 0, 0, "sat_hold");
    chk(0, 0, 0, 0, 1, 16'h5959, 0, 0, "sat_hold_next");
    chk(0, 0, 0, 0, 4, 16'h5959, 0, 0, "sat_later_event");
`else
    chk(0, 0, 0, 0, 1, 16'h0000, 1, 1, "wrap_pulse");
    chk(0, 0, 0, 0, 1, 16'h0000, 0, 0, "wrap_one_cycle");
    chk(0, 0, 0, 0, 3, 16'h0001, 1, 0, "after_wrap");
`endif

    // Reset colliding with a run-mode increment at 12:34
    chk(1, 0, 0, 0,  1, 16'h0000, 0, 0, "rst2");
    chk(0, 0, 1, 1,  1, 16'h0000, 0, 0, "adj_clear");
    chk(0, 0, 1, 1, 24, 16'h1200, 1, 0, "preload_min");
    chk(0, 0, 1, 0, 68, 16'h1234, 1, 0, "preload_sec");
    chk(0, 0, 0, 0,  4, 16'h1234, 0, 0, "pre_collision");
    chk(1, 0, 0, 0,  1, 16'h0000, 0, 0, "rst_wins");
    chk(0, 0, 0, 0,  3, 16'h0000, 0, 0, "post_rst_wait");
    chk(0, 0, 0, 0,  1, 16'h0001, 1, 0, "post_rst_first");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
